// File: rtl/hadamard_pkg.sv
// Shared definitions for the complexhadamard start/done protocol:
// FSM state encoding, lane count and lane-packing helpers.
package hadamard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } hd_state_e;

    localparam int LANES     = 4;
    localparam int DEF_FMT_W = 9;
    localparam int DEF_BUS_W = DEF_FMT_W * LANES;

    // Lane k of a packed bus occupies [lane_lsb(k)+fmt_w-1 : lane_lsb(k)].
    function automatic int lane_lsb(input int lane, input int fmt_w);
        return lane * fmt_w;
    endfunction

endpackage

// File: rtl/hd_watchdog.sv
// Butterfly watchdog: counts cycles while enabled, clears on request,
// fire_o asserts while enabled and the count has reached TIMEOUT.
// Ports: clk, rst (async active-low), clr_i, en_i, fire_o.
module hd_watchdog #(
    parameter int TIMEOUT = 15,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic fire_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fire_o = en_i && (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/hadamard_issuer.sv
// Initiator for complexhadamard: latches one 4-lane group per beat, pulses
// hd_start, waits for hd_done, holds the result on out_* until taken.
// Ports: clk/rst (async active-low); in_* upstream valid/ready + operands;
// hd_* butterfly handshake; out_* downstream valid/ready + result/last;
// err_timeout sticky watchdog flag.
module hadamard_issuer
    import hadamard_pkg::*;
#(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = 9,
    parameter int GROUPS      = 16,
    parameter int TIMEOUT     = 15,
    parameter int BW          = formatWidth * LANES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_real,
    input  logic [BW-1:0] in_imag,
    input  logic [BW-1:0] tw_real,
    input  logic [BW-1:0] tw_imag,
    output logic          hd_start,
    output logic [BW-1:0] hd_input_real,
    output logic [BW-1:0] hd_input_imag,
    output logic [BW-1:0] hd_twiddle_real,
    output logic [BW-1:0] hd_twiddle_imag,
    input  logic [BW-1:0] hd_output_real,
    input  logic [BW-1:0] hd_output_imag,
    input  logic          hd_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_real,
    output logic [BW-1:0] out_imag,
    output logic          out_last,
    output logic          err_timeout
);

    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if (formatWidth != expWidth + sigWidth + 1) begin : g_fmt_chk
        $error("formatWidth must equal expWidth+sigWidth+1");
    end
    if (TIMEOUT < 5) begin : g_to_chk
        $error("TIMEOUT must be at least 5");
    end

    hd_state_e     state_q, state_d;
    logic [BW-1:0] ir_q, ir_d, ii_q, ii_d;
    logic [BW-1:0] tr_q, tr_d, ti_q, ti_d;
    logic [BW-1:0] or_q, or_d, oi_q, oi_d;
    logic          ov_q, ov_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic [GW-1:0] gidx_q, gidx_d;
    logic          accept;
    logic          wd_fire;
    logic          is_last;

    // Result register must be empty (or draining) before a new group starts.
    assign in_ready = (state_q == ST_IDLE) && (!ov_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_last  = (gidx_q == GW'(GROUPS - 1));

    hd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != ST_WAIT),
        .en_i   (state_q == ST_WAIT),
        .fire_o (wd_fire)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ii_d    = ii_q;
        tr_d    = tr_q;
        ti_d    = ti_q;
        or_d    = or_q;
        oi_d    = oi_q;
        ov_d    = ov_q;
        last_d  = last_q;
        err_d   = err_q;
        gidx_d  = gidx_q;

        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ir_d    = in_real;
                    ii_d    = in_imag;
                    tr_d    = tw_real;
                    ti_d    = tw_imag;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority over a watchdog firing in the same cycle.
                if (hd_done) begin
                    or_d    = hd_output_real;
                    oi_d    = hd_output_imag;
                    ov_d    = 1'b1;
                    last_d  = is_last;
                    gidx_d  = is_last ? '0 : gidx_q + 1'b1;
                    state_d = ST_IDLE;
                end else if (wd_fire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            ii_q    <= '0;
            tr_q    <= '0;
            ti_q    <= '0;
            or_q    <= '0;
            oi_q    <= '0;
            ov_q    <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ii_q    <= ii_d;
            tr_q    <= tr_d;
            ti_q    <= ti_d;
            or_q    <= or_d;
            oi_q    <= oi_d;
            ov_q    <= ov_d;
            last_q  <= last_d;
            err_q   <= err_d;
            gidx_q  <= gidx_d;
        end
    end

    assign hd_start        = (state_q == ST_ISSUE);
    assign hd_input_real   = ir_q;
    assign hd_input_imag   = ii_q;
    assign hd_twiddle_real = tr_q;
    assign hd_twiddle_imag = ti_q;
    assign out_valid       = ov_q;
    assign out_real        = or_q;
    assign out_imag        = oi_q;
    assign out_last        = last_q;
    assign err_timeout     = err_q;

endmodule

// File: tb/tb_hadamard_issuer.sv
// Self-checking bench for hadamard_issuer with a behavioural
// complexhadamard stub and an in-order result scoreboard.
module tb_hadamard_issuer;

    localparam int BW = 36;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_real = '0, in_imag = '0;
    logic [BW-1:0] tw_real = '0, tw_imag = '0;
    logic          hd_start;
    logic [BW-1:0] hd_input_real, hd_input_imag;
    logic [BW-1:0] hd_twiddle_real, hd_twiddle_imag;
    logic [BW-1:0] hd_output_real, hd_output_imag;
    logic          hd_done;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_real, out_imag;
    logic          out_last;
    logic          err_timeout;

    always #5 clk = ~clk;

    hadamard_issuer dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_real         (in_real),
        .in_imag         (in_imag),
        .tw_real         (tw_real),
        .tw_imag         (tw_imag),
        .hd_start        (hd_start),
        .hd_input_real   (hd_input_real),
        .hd_input_imag   (hd_input_imag),
        .hd_twiddle_real (hd_twiddle_real),
        .hd_twiddle_imag (hd_twiddle_imag),
        .hd_output_real  (hd_output_real),
        .hd_output_imag  (hd_output_imag),
        .hd_done         (hd_done),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_real        (out_real),
        .out_imag        (out_imag),
        .out_last        (out_last),
        .err_timeout     (err_timeout)
    );

    // Butterfly stub: done pulses stub_delay cycles after start (0 = never).
    int   stub_delay = 4;
    int   stub_cnt;
    logic spur_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) stub_cnt <= 0;
        else if (hd_start) stub_cnt <= stub_delay;
        else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
    end

    assign hd_done        = (stub_cnt == 1) || spur_done;
    assign hd_output_real = hd_input_real ^ hd_twiddle_real;
    assign hd_output_imag = hd_input_imag + hd_twiddle_imag;

    typedef struct {
        logic [BW-1:0] ir, ii, tr, ti;
        logic [BW-1:0] er, ei;
    } vec_t;

    typedef struct {
        logic [BW-1:0] r, i;
        logic          last;
    } exp_t;

    vec_t tbl[8];
    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   model_idx = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", out_real);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_real", out_real, mon_e.r);
                chk("out_imag", out_imag, mon_e.i);
                chk("out_last", BW'(out_last), BW'(mon_e.last));
            end
        end
    end

    // Present entry k; returns at accept-edge + 1 (cycle 1 of the group).
    task automatic send(input int k, input bit drop);
        int n;
        in_real  = tbl[k].ir;
        in_imag  = tbl[k].ii;
        tw_real  = tbl[k].tr;
        tw_imag  = tbl[k].ti;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck 0 for %0d cycles", n);
        end
        @(posedge clk);
        if (!drop) begin
            sbq.push_back('{r: tbl[k].er, i: tbl[k].ei,
                            last: (model_idx == 15)});
            model_idx = (model_idx + 1) % 16;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        model_idx = 0;
        sbq.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] r64;
        int n;
        for (int k = 0; k < 8; k++) begin
            r64 = {$urandom(), $urandom()};
            tbl[k].ir = r64[BW-1:0];
            r64 = {$urandom(), $urandom()};
            tbl[k].ii = r64[BW-1:0];
            r64 = {$urandom(), $urandom()};
            tbl[k].tr = r64[BW-1:0];
            r64 = {$urandom(), $urandom()};
            tbl[k].ti = r64[BW-1:0];
        end
        tbl[0].ir = '0;
        tbl[0].tr = '1;
        tbl[0].ii = '1;
        tbl[0].ti = 36'd1;
        for (int k = 0; k < 8; k++) begin
            tbl[k].er = tbl[k].ir ^ tbl[k].tr;
            tbl[k].ei = tbl[k].ii + tbl[k].ti;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hd_start", BW'(hd_start), '0);
        chk("rst_out_valid", BW'(out_valid), '0);
        chk("rst_out_last", BW'(out_last), '0);
        chk("rst_err", BW'(err_timeout), '0);
        chk("rst_out_real", out_real, '0);
        chk("rst_hd_in", hd_input_real, '0);
        chk("rst_hd_tw", hd_twiddle_imag, '0);
        chk("rst_in_ready", BW'(in_ready), BW'(1));
        #1 rst = 1'b1;

        // Single group latency: start in cycle 1, out_valid in cycle 6
        send(0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            chk("t1_start", BW'(hd_start), BW'(c == 1));
            chk("t1_valid", BW'(out_valid), BW'(c == 6));
            chk("t1_operand", hd_input_real, tbl[0].ir);
            @(posedge clk);
            #1;
        end
        wait_drain();

        // 17 back-to-back groups: last only on the 16th
        apply_reset();
        for (int i = 0; i < 17; i++) send(i % 8, 1'b0);
        wait_drain();

        // Downstream stall
        out_ready = 1'b0;
        send(1, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t3_got_valid", BW'(out_valid), BW'(1));
        @(posedge clk);
        #1;
        in_real  = tbl[2].ir;
        in_imag  = tbl[2].ii;
        tw_real  = tbl[2].tr;
        tw_imag  = tbl[2].ti;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t3_hold_valid", BW'(out_valid), BW'(1));
            chk("t3_hold_real", out_real, tbl[1].er);
            chk("t3_hold_imag", out_imag, tbl[1].ei);
            chk("t3_in_ready", BW'(in_ready), '0);
            chk("t3_no_start", BW'(hd_start), '0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(2, 1'b0);
        wait_drain();

        // Watchdog: no done, WAIT cycles 2..17, error from cycle 18
        stub_delay = 0;
        send(3, 1'b1);
        for (int c = 1; c <= 18; c++) begin
            chk("t4_err", BW'(err_timeout), BW'(c == 18));
            chk("t4_no_valid", BW'(out_valid), '0);
            if (c >= 16) chk("t4_in_ready", BW'(in_ready), BW'(c == 18));
            @(posedge clk);
            #1;
        end
        stub_delay = 4;
        send(4, 1'b0);
        wait_drain();
        chk("t4_err_sticky", BW'(err_timeout), BW'(1));

        // Spurious done in IDLE, then done on the timeout cycle
        apply_reset();
        chk("t5_err_cleared", BW'(err_timeout), '0);
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        chk("t5_spur_valid", BW'(out_valid), '0);
        chk("t5_spur_start", BW'(hd_start), '0);
        chk("t5_spur_ready", BW'(in_ready), BW'(1));
        stub_delay = 16;
        send(5, 1'b0);
        wait_drain();
        chk("t5_err_edge", BW'(err_timeout), '0);
        stub_delay = 4;

        // Asynchronous reset during WAIT
        send(6, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_hd_start", BW'(hd_start), '0);
        chk("t6_hd_in", hd_input_real, '0);
        chk("t6_hd_tw", hd_twiddle_real, '0);
        chk("t6_valid", BW'(out_valid), '0);
        chk("t6_out_real", out_real, '0);
        chk("t6_in_ready", BW'(in_ready), BW'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        model_idx = 0;
        sbq.delete();
        send(7, 1'b0);
        wait_drain();

        chk("final_queue", BW'(sbq.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
